// File: rtl/mem_bank_timing_pkg.sv
// Shared types for the multi-bank DRAM timing emulator: per-bank state
// encoding, command encoding and the bank-index width helper.
package mem_timing_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ACTIVATING  = 3'd1,
        ACTIVE      = 3'd2,
        READING     = 3'd3,
        WRITING     = 3'd4,
        PRECHARGING = 3'd5,
        REFRESHING  = 3'd6,
        ROWCLONE    = 3'd7
    } bank_state_t;

    typedef enum logic [2:0] {
        CMD_NOP  = 3'd0,
        CMD_ACT  = 3'd1,
        CMD_RD   = 3'd2,
        CMD_WR   = 3'd3,
        CMD_PRE  = 3'd4,
        CMD_PREA = 3'd5,
        CMD_REF  = 3'd6,
        CMD_RSVD = 3'd7
    } cmd_t;

    // Bank index width; a single-bank build still carries a 1-bit index.
    function automatic int bank_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bank_timing_if.sv
// Command/status bundle between the command decoder (master) and the
// bank timing emulator (slave).
interface mem_bank_timing_if
    import mem_timing_pkg::*;
#(
    parameter int NUM_BANKS = 8
);
    localparam int BANK_W = bank_w(NUM_BANKS);

    logic                   cmd_valid;
    logic [2:0]             cmd;
    logic [BANK_W-1:0]      cmd_bank;
    logic                   cmd_ap;
    logic                   cmd_accept;
    logic                   cmd_error;
    logic [3*NUM_BANKS-1:0] bank_state;
    logic                   rd_valid;
    logic                   wr_valid;
    logic                   all_idle;

    modport master (
        output cmd_valid, cmd, cmd_bank, cmd_ap,
        input  cmd_accept, cmd_error, bank_state, rd_valid, wr_valid, all_idle
    );

    modport slave (
        input  cmd_valid, cmd, cmd_bank, cmd_ap,
        output cmd_accept, cmd_error, bank_state, rd_valid, wr_valid, all_idle
    );

endinterface

// File: rtl/mem_bank_timing_fsm.sv
// One bank's timing FSM: state register, phase counter, tRAS counter,
// per-bank legality flags and data-window flags.
// Optional feature: define ROWCLONE_EN to allow ACT on an ACTIVE bank
// (ACTIVE -> ROWCLONE -> ACTIVE, tRAS reloaded).
module mem_bank_fsm
    import mem_timing_pkg::*;
#(
    parameter int CTR_W = 10,
    parameter int T_RCD = 17,
    parameter int T_CL  = 17,
    parameter int T_RAS = 39,
    parameter int T_WR  = 18,
    parameter int T_RP  = 17,
    parameter int T_RFC = 347,
    parameter int BURST = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        do_act,
    input  logic        do_rd,
    input  logic        do_wr,
    input  logic        do_pre,
    input  logic        do_ref,
    input  logic        ap,
    output bank_state_t state,
    output logic        act_ok,
    output logic        col_ok,
    output logic        pre_ok,
    output logic        bus_busy,
    output logic        rd_win,
    output logic        wr_win,
    output logic        idle
);
    localparam logic [CTR_W-1:0] ZERO  = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] ONE   = CTR_W'(1);
    localparam logic [CTR_W-1:0] RCD_L = CTR_W'(T_RCD);
    localparam logic [CTR_W-1:0] RAS_L = CTR_W'(T_RAS);
    localparam logic [CTR_W-1:0] RD_L  = CTR_W'(T_CL + BURST);
    localparam logic [CTR_W-1:0] WR_L  = CTR_W'(BURST + T_WR);
    localparam logic [CTR_W-1:0] RP_L  = CTR_W'(T_RP);
    localparam logic [CTR_W-1:0] RFC_L = CTR_W'(T_RFC);
    localparam logic [CTR_W-1:0] BL_L  = CTR_W'(BURST);
    localparam logic [CTR_W-1:0] TWR_L = CTR_W'(T_WR);

    bank_state_t      state_r;
    logic [CTR_W-1:0] cnt_r;
    logic [CTR_W-1:0] tras_r;
    logic             ap_r;
    logic [CTR_W-1:0] tras_dec_s;
    logic [CTR_W:0]   ap_sum_s;
    logic [CTR_W-1:0] ap_wait_s;
    logic             last_s;

    assign last_s = (cnt_r == ONE);

    // tRAS value for the next cycle, and the auto-precharge wait that
    // folds the still-unexpired tRAS into the precharge time.
    always_comb begin
        if (tras_r == ZERO) begin
            tras_dec_s = ZERO;
        end else begin
            tras_dec_s = tras_r - ONE;
        end
        ap_sum_s = {1'b0, tras_dec_s} + (CTR_W+1)'(T_RP);
        if (ap_sum_s[CTR_W]) begin
            ap_wait_s = {CTR_W{1'b1}};
        end else begin
            ap_wait_s = ap_sum_s[CTR_W-1:0];
        end
    end

    // tRAS counter: loads on every activation, saturates at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tras_r <= ZERO;
        end else if (do_act) begin
            tras_r <= RAS_L;
        end else begin
            tras_r <= tras_dec_s;
        end
    end

    // Bank state machine: commands enter timed states, counter expiry leaves them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= ZERO;
            ap_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (do_ref) begin
                        state_r <= REFRESHING;
                        cnt_r   <= RFC_L;
                    end else if (do_act) begin
                        state_r <= ACTIVATING;
                        cnt_r   <= RCD_L;
                    end else begin
                        state_r <= IDLE;
                        cnt_r   <= ZERO;
                    end
                end
                ACTIVE: begin
                    if (do_rd) begin
                        state_r <= READING;
                        cnt_r   <= RD_L;
                        ap_r    <= ap;
                    end else if (do_wr) begin
                        state_r <= WRITING;
                        cnt_r   <= WR_L;
                        ap_r    <= ap;
                    end else if (do_pre) begin
                        state_r <= PRECHARGING;
                        cnt_r   <= RP_L;
`ifdef ROWCLONE_EN
                    end else if (do_act) begin
                        state_r <= ROWCLONE;
                        cnt_r   <= RCD_L;
`endif
                    end else begin
                        state_r <= ACTIVE;
                        cnt_r   <= ZERO;
                    end
                end
                ACTIVATING, ROWCLONE: begin
                    if (last_s) begin
                        state_r <= ACTIVE;
                        cnt_r   <= ZERO;
                    end else begin
                        cnt_r   <= cnt_r - ONE;
                    end
                end
                READING, WRITING: begin
                    if (last_s && ap_r) begin
                        state_r <= PRECHARGING;
                        cnt_r   <= ap_wait_s;
                    end else if (last_s) begin
                        state_r <= ACTIVE;
                        cnt_r   <= ZERO;
                    end else begin
                        cnt_r   <= cnt_r - ONE;
                    end
                end
                PRECHARGING, REFRESHING: begin
                    if (last_s) begin
                        state_r <= IDLE;
                        cnt_r   <= ZERO;
                    end else begin
                        cnt_r   <= cnt_r - ONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= ZERO;
                end
            endcase
        end
    end

    assign state    = state_r;
`ifdef ROWCLONE_EN
    assign act_ok   = (state_r == IDLE) || (state_r == ACTIVE);
`else
    assign act_ok   = (state_r == IDLE);
`endif
    assign col_ok   = (state_r == ACTIVE);
    assign pre_ok   = (state_r == ACTIVE) && (tras_r == ZERO);
    assign bus_busy = (state_r == READING) || (state_r == WRITING);
    // Read data occupies the last BURST cycles of READING, write data the first BURST of WRITING.
    assign rd_win   = (state_r == READING) && (cnt_r <= BL_L);
    assign wr_win   = (state_r == WRITING) && (cnt_r > TWR_L);
    assign idle     = (state_r == IDLE);

endmodule

// File: rtl/mem_bank_timing.sv
// Multi-bank DRAM timing emulator top: command decode, cross-bank legality
// (data-bus conflict, all-idle for REF, PREA), error pulse and window OR.
// Optional feature: define ROWCLONE_EN to enable ACTIVE + ACT -> ROWCLONE.
module mem_bank_timing
    import mem_timing_pkg::*;
#(
    parameter int NUM_BANKS = 8,
    parameter int CTR_W     = 10,
    parameter int T_RCD     = 17,
    parameter int T_CL      = 17,
    parameter int T_RAS     = 39,
    parameter int T_WR      = 18,
    parameter int T_RP      = 17,
    parameter int T_RFC     = 347,
    parameter int BURST     = 4
) (
    input  logic              clk,
    input  logic              rst,
    mem_bank_timing_if.slave  bus
);
    localparam int BANK_W = bank_w(NUM_BANKS);
    localparam logic [NUM_BANKS-1:0] NONE = {NUM_BANKS{1'b0}};
    localparam logic [NUM_BANKS-1:0] ALL  = {NUM_BANKS{1'b1}};

    cmd_t                 cmd_s;
    logic [NUM_BANKS-1:0] bank_sel_s;
    logic [NUM_BANKS-1:0] act_ok_v, col_ok_v, pre_ok_v, busy_v, rd_win_v, wr_win_v, idle_v;
    logic [NUM_BANKS-1:0] do_act_v, do_rd_v, do_wr_v, do_pre_v, do_ref_v;
    logic                 legal_s;
    logic                 accept_s;
    logic                 cmd_error_r;

    assign cmd_s = cmd_t'(bus.cmd);

    // One-hot target bank; an out-of-range index selects nothing and is rejected.
    always_comb begin
        bank_sel_s = NONE;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bus.cmd_bank == BANK_W'(i)) begin
                bank_sel_s[i] = 1'b1;
            end else begin
                bank_sel_s[i] = 1'b0;
            end
        end
    end

    // Global legality check for the presented command.
    always_comb begin
        case (cmd_s)
            CMD_NOP:         legal_s = 1'b1;
            CMD_ACT:         legal_s = |(bank_sel_s & act_ok_v);
            CMD_RD, CMD_WR:  legal_s = (|(bank_sel_s & col_ok_v)) && !(|busy_v);
            CMD_PRE:         legal_s = |(bank_sel_s & pre_ok_v);
            CMD_PREA:        legal_s = &(idle_v | pre_ok_v);
            CMD_REF:         legal_s = &idle_v;
            default:         legal_s = 1'b0;
        endcase
        accept_s = bus.cmd_valid && legal_s;
    end

    // Fan the accepted command out to the banks it affects.
    always_comb begin
        do_act_v = NONE;
        do_rd_v  = NONE;
        do_wr_v  = NONE;
        do_pre_v = NONE;
        do_ref_v = NONE;
        if (accept_s) begin
            case (cmd_s)
                CMD_ACT:  do_act_v = bank_sel_s;
                CMD_RD:   do_rd_v  = bank_sel_s;
                CMD_WR:   do_wr_v  = bank_sel_s;
                CMD_PRE:  do_pre_v = bank_sel_s;
                CMD_PREA: do_pre_v = pre_ok_v;
                CMD_REF:  do_ref_v = ALL;
                default:  do_act_v = NONE;
            endcase
        end else begin
            do_act_v = NONE;
        end
    end

    // Error pulse for a valid command rejected in the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_error_r <= 1'b0;
        end else begin
            cmd_error_r <= bus.cmd_valid && !legal_s;
        end
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        bank_state_t st_s;

        mem_bank_fsm #(
            .CTR_W (CTR_W), .T_RCD (T_RCD), .T_CL (T_CL), .T_RAS (T_RAS),
            .T_WR  (T_WR),  .T_RP  (T_RP),  .T_RFC (T_RFC), .BURST (BURST)
        ) u_fsm (
            .clk      (clk),
            .rst      (rst),
            .do_act   (do_act_v[g]),
            .do_rd    (do_rd_v[g]),
            .do_wr    (do_wr_v[g]),
            .do_pre   (do_pre_v[g]),
            .do_ref   (do_ref_v[g]),
            .ap       (bus.cmd_ap),
            .state    (st_s),
            .act_ok   (act_ok_v[g]),
            .col_ok   (col_ok_v[g]),
            .pre_ok   (pre_ok_v[g]),
            .bus_busy (busy_v[g]),
            .rd_win   (rd_win_v[g]),
            .wr_win   (wr_win_v[g]),
            .idle     (idle_v[g])
        );

        assign bus.bank_state[3*g +: 3] = st_s;
    end

    assign bus.cmd_accept = accept_s;
    assign bus.cmd_error  = cmd_error_r;
    assign bus.rd_valid   = |rd_win_v;
    assign bus.wr_valid   = |wr_win_v;
    assign bus.all_idle   = &idle_v;

endmodule

// File: tb/tb_mem_bank_timing.sv
// Self-checking bench for mem_bank_timing: reset-state vector table,
// directed timing sequences, and randomized commands against a
// timestamp-based reference model.
module tb_mem_bank_timing;
    import mem_timing_pkg::*;

    localparam int NB = 8, BW = 3;
    localparam int T_RCD = 17, T_CL = 17, T_RAS = 39, T_WR = 18, T_RP = 17, T_RFC = 347, BURST = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_bank_timing_if #(.NUM_BANKS(NB)) bus ();

    mem_bank_timing #(
        .NUM_BANKS(NB), .CTR_W(10), .T_RCD(T_RCD), .T_CL(T_CL), .T_RAS(T_RAS),
        .T_WR(T_WR), .T_RP(T_RP), .T_RFC(T_RFC), .BURST(BURST)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Reference model: per bank, the current state, the cycle its timed phase
    // started and the first cycle of the following phase, plus the first cycle
    // on which PRE is allowed (tRAS satisfied).
    bank_state_t m_st [NB];
    int          m_start [NB];
    int          m_end [NB];
    int          m_ras [NB];
    bit          m_ap [NB];
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [2:0] bst(input int b);
        return bus.bank_state[3*b +: 3];
    endfunction

    function automatic void m_reset();
        for (int b = 0; b < NB; b++) begin
            m_st[b] = IDLE; m_start[b] = 0; m_end[b] = 0; m_ras[b] = 0; m_ap[b] = 0;
        end
        m_err = 0;
    endfunction

    // Phase expiries at the start of cycle c.
    function automatic void m_tick(input int c);
        for (int b = 0; b < NB; b++) begin
            if (m_st[b] != IDLE && m_st[b] != ACTIVE && c == m_end[b]) begin
                case (m_st[b])
                    ACTIVATING, ROWCLONE: m_st[b] = ACTIVE;
                    READING, WRITING: begin
                        if (m_ap[b]) begin
                            m_st[b]  = PRECHARGING;
                            m_start[b] = c;
                            m_end[b] = c + T_RP + ((m_ras[b] > c) ? (m_ras[b] - c) : 0);
                        end else begin
                            m_st[b] = ACTIVE;
                        end
                    end
                    default: m_st[b] = IDLE;
                endcase
            end
        end
    endfunction

    function automatic bit m_legal(input int c, input logic [2:0] cmd, input int b);
        bit busy = 0, allidle = 1, prea = 1;
        for (int i = 0; i < NB; i++) begin
            if (m_st[i] == READING || m_st[i] == WRITING) busy = 1;
            if (m_st[i] != IDLE) allidle = 0;
            if (m_st[i] != IDLE && !(m_st[i] == ACTIVE && c >= m_ras[i])) prea = 0;
        end
        case (cmd_t'(cmd))
            CMD_NOP:  return 1;
`ifdef ROWCLONE_EN
            CMD_ACT:  return m_st[b] == IDLE || m_st[b] == ACTIVE;
`else
            CMD_ACT:  return m_st[b] == IDLE;
`endif
            CMD_RD, CMD_WR: return m_st[b] == ACTIVE && !busy;
            CMD_PRE:  return m_st[b] == ACTIVE && c >= m_ras[b];
            CMD_PREA: return prea;
            CMD_REF:  return allidle;
            default:  return 0;
        endcase
    endfunction

    function automatic void m_enter(input int b, input bank_state_t s, input int c, input int n);
        m_st[b] = s; m_start[b] = c + 1; m_end[b] = c + 1 + n;
    endfunction

    function automatic void m_apply(input int c, input logic [2:0] cmd, input int b, input bit ap);
        case (cmd_t'(cmd))
            CMD_ACT: begin
                m_enter(b, (m_st[b] == IDLE) ? ACTIVATING : ROWCLONE, c, T_RCD);
                m_ras[b] = c + 1 + T_RAS;
            end
            CMD_RD:  begin m_enter(b, READING, c, T_CL + BURST); m_ap[b] = ap; end
            CMD_WR:  begin m_enter(b, WRITING, c, BURST + T_WR); m_ap[b] = ap; end
            CMD_PRE: m_enter(b, PRECHARGING, c, T_RP);
            CMD_PREA: for (int i = 0; i < NB; i++) if (m_st[i] == ACTIVE) m_enter(i, PRECHARGING, c, T_RP);
            CMD_REF:  for (int i = 0; i < NB; i++) m_enter(i, REFRESHING, c, T_RFC);
            default: m_err = m_err;
        endcase
    endfunction

    function automatic logic [3*NB-1:0] m_pack();
        logic [3*NB-1:0] e = '0;
        for (int b = 0; b < NB; b++) e[3*b +: 3] = m_st[b];
        return e;
    endfunction

    // One clock cycle: drive, compare every output with the model, advance.
    task automatic step(input logic v, input logic [2:0] cmd, input int b, input logic ap);
        bit lg, rdx, wrx, idx;
        @(negedge clk);
        bus.cmd_valid = v; bus.cmd = cmd; bus.cmd_bank = BW'(b); bus.cmd_ap = ap;
        m_tick(cyc);
        lg = m_legal(cyc, cmd, b);
        rdx = 0; wrx = 0; idx = 1;
        for (int i = 0; i < NB; i++) begin
            if (m_st[i] == READING && cyc >= m_end[i] - BURST) rdx = 1;
            if (m_st[i] == WRITING && cyc < m_start[i] + BURST) wrx = 1;
            if (m_st[i] != IDLE) idx = 0;
        end
        #1;
        chk("model bank_state", 32'(bus.bank_state), 32'(m_pack()));
        chk("model all_idle",   32'(bus.all_idle),   32'(idx));
        chk("model rd_valid",   32'(bus.rd_valid),   32'(rdx));
        chk("model wr_valid",   32'(bus.wr_valid),   32'(wrx));
        chk("model cmd_accept", 32'(bus.cmd_accept), 32'(v && lg));
        chk("model cmd_error",  32'(bus.cmd_error),  32'(m_err));
        m_err = v && !lg;
        if (v && lg) m_apply(cyc, cmd, b, ap);
        cyc++;
    endtask

    task automatic nops(input int n);
        repeat (n) step(1'b0, 3'd0, 0, 1'b0);
    endtask

    // Asynchronous reset away from any clock edge; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd = 3'd0; bus.cmd_bank = '0; bus.cmd_ap = 1'b0;
        #1;
        chk("reset bank_state", 32'(bus.bank_state), 32'd0);
        chk("reset all_idle",   32'(bus.all_idle),   32'd1);
        chk("reset rd_valid",   32'(bus.rd_valid),   32'd0);
        chk("reset wr_valid",   32'(bus.wr_valid),   32'd0);
        chk("reset cmd_error",  32'(bus.cmd_error),  32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        cyc += 3;
    endtask

    typedef struct {
        logic [2:0]  cmd;
        int          bank;
        logic        acc;
        logic        err;
        bank_state_t st;
    } vec_t;

    vec_t vt [9];
    logic [3*NB-1:0] all_ref;

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd = 3'd0; bus.cmd_bank = '0; bus.cmd_ap = 1'b0;
        for (int b = 0; b < NB; b++) all_ref[3*b +: 3] = REFRESHING;

        // Single commands issued from the reset state.
        vt[0] = '{CMD_NOP,  0, 1'b1, 1'b0, IDLE};
        vt[1] = '{CMD_ACT,  3, 1'b1, 1'b0, ACTIVATING};
        vt[2] = '{CMD_RD,   0, 1'b0, 1'b1, IDLE};
        vt[3] = '{CMD_WR,   5, 1'b0, 1'b1, IDLE};
        vt[4] = '{CMD_PRE,  2, 1'b0, 1'b1, IDLE};
        vt[5] = '{CMD_PREA, 0, 1'b1, 1'b0, IDLE};
        vt[6] = '{CMD_REF,  7, 1'b1, 1'b0, REFRESHING};
        vt[7] = '{CMD_RSVD, 1, 1'b0, 1'b1, IDLE};
        vt[8] = '{CMD_ACT,  7, 1'b1, 1'b0, ACTIVATING};
        for (int i = 0; i < 9; i++) begin
            do_reset();
            step(1'b1, vt[i].cmd, vt[i].bank, 1'b0);
            chk("vec accept", 32'(bus.cmd_accept), 32'(vt[i].acc));
            nops(1);
            chk("vec error", 32'(bus.cmd_error), 32'(vt[i].err));
            chk("vec state", 32'(bst(vt[i].bank)), 32'(vt[i].st));
        end

        // ACT timing, early RD rejection, read window position.
        do_reset();
        step(1'b1, CMD_ACT, 0, 1'b0);
        nops(1);
        chk("act t0+1 activating", 32'(bst(0)), 32'(ACTIVATING));
        nops(15);
        step(1'b1, CMD_RD, 0, 1'b0);
        chk("rd early accept", 32'(bus.cmd_accept), 32'd0);
        chk("act t0+17 activating", 32'(bst(0)), 32'(ACTIVATING));
        nops(1);
        chk("act t0+18 active", 32'(bst(0)), 32'(ACTIVE));
        chk("rd early error", 32'(bus.cmd_error), 32'd1);
        step(1'b1, CMD_RD, 0, 1'b0);
        chk("rd accept", 32'(bus.cmd_accept), 32'd1);
        for (int k = 1; k <= 22; k++) begin
            nops(1);
            chk("rd window", 32'(bus.rd_valid), 32'((k >= 18 && k <= 21) ? 1 : 0));
        end
        chk("rd done active", 32'(bst(0)), 32'(ACTIVE));

        // tRAS gating of PRE.
        do_reset();
        step(1'b1, CMD_ACT, 1, 1'b0);
        nops(19);
        step(1'b1, CMD_PRE, 1, 1'b0);
        chk("pre tras accept", 32'(bus.cmd_accept), 32'd0);
        nops(19);
        step(1'b1, CMD_PRE, 1, 1'b0);
        chk("pre ok accept", 32'(bus.cmd_accept), 32'd1);
        nops(17);
        chk("pre t57", 32'(bst(1)), 32'(PRECHARGING));
        nops(1);
        chk("pre t58 idle", 32'(bst(1)), 32'(IDLE));

        // REF blocked by an open bank, PREA, then full refresh and reset mid-refresh.
        do_reset();
        step(1'b1, CMD_ACT, 0, 1'b0);
        nops(39);
        step(1'b1, CMD_REF, 0, 1'b0);
        chk("ref busy accept", 32'(bus.cmd_accept), 32'd0);
        nops(1);
        chk("ref busy error", 32'(bus.cmd_error), 32'd1);
        step(1'b1, CMD_PREA, 0, 1'b0);
        chk("prea accept", 32'(bus.cmd_accept), 32'd1);
        nops(18);
        chk("prea all_idle", 32'(bus.all_idle), 32'd1);
        step(1'b1, CMD_REF, 0, 1'b0);
        chk("ref accept", 32'(bus.cmd_accept), 32'd1);
        nops(1);
        chk("ref first", 32'(bus.bank_state), 32'(all_ref));
        nops(346);
        chk("ref last", 32'(bus.bank_state), 32'(all_ref));
        nops(1);
        chk("ref done", 32'(bus.all_idle), 32'd1);
        step(1'b1, CMD_REF, 0, 1'b0);
        nops(5);
        chk("ref again", 32'(bus.bank_state), 32'(all_ref));
        do_reset();

        // Data-bus conflict while a write window is open.
        step(1'b1, CMD_ACT, 0, 1'b0);
        step(1'b1, CMD_ACT, 3, 1'b0);
        nops(17);
        step(1'b1, CMD_WR, 0, 1'b0);
        chk("wr accept", 32'(bus.cmd_accept), 32'd1);
        step(1'b1, CMD_RD, 3, 1'b0);
        chk("bus conflict accept", 32'(bus.cmd_accept), 32'd0);
        chk("wr window 1", 32'(bus.wr_valid), 32'd1);
        for (int k = 0; k < 4; k++) begin
            nops(1);
            chk("wr window", 32'(bus.wr_valid), 32'((k < 3) ? 1 : 0));
        end

        // ACT to an already open bank.
        do_reset();
        step(1'b1, CMD_ACT, 0, 1'b0);
        nops(18);
        step(1'b1, CMD_ACT, 0, 1'b0);
`ifdef ROWCLONE_EN
        chk("rowclone accept", 32'(bus.cmd_accept), 32'd1);
        nops(1);
        chk("rowclone first", 32'(bst(0)), 32'(ROWCLONE));
        nops(16);
        chk("rowclone last", 32'(bst(0)), 32'(ROWCLONE));
        nops(1);
        chk("rowclone done", 32'(bst(0)), 32'(ACTIVE));
`else
        chk("act open accept", 32'(bus.cmd_accept), 32'd0);
        nops(1);
        chk("act open error", 32'(bus.cmd_error), 32'd1);
        chk("act open state", 32'(bst(0)), 32'(ACTIVE));
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            int r;
            logic [2:0] c;
            r = $urandom_range(0, 99);
            if (r < 22)      c = CMD_ACT;
            else if (r < 38) c = CMD_RD;
            else if (r < 54) c = CMD_WR;
            else if (r < 70) c = CMD_PRE;
            else if (r < 76) c = CMD_PREA;
            else if (r < 79) c = CMD_REF;
            else if (r < 81) c = CMD_RSVD;
            else             c = CMD_NOP;
            step(logic'($urandom_range(0, 9) != 0), c, int'($urandom_range(0, NB-1)),
                 logic'($urandom_range(0, 1)));
            if (n == 2000) do_reset();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
